// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and inverse-cipher column/row helpers
// used by the byte-serial decryptor.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        IDLE, LOAD_KEY, EXPAND, LOAD_IV, READY, LOAD_CT, ROUND, OUTPUT
    } state_t;

    // RCON[1..10]; any other index yields zero
    function automatic byte_t rcon(logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic byte_t xtime(byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(byte_t a, logic [3:0] k);
        byte_t p = 8'h00;
        byte_t x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t inv_mix_column(word_t w);
        byte_t a0 = w[31:24];
        byte_t a1 = w[23:16];
        byte_t a2 = w[15:8];
        byte_t a3 = w[7:0];
        return {gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
                gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
                gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
                gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)};
    endfunction

    // Byte 0 is the most significant byte of a block
    function automatic byte_t get_byte(block_t b, logic [3:0] i);
        return b[{~i, 3'b000} +: 8];
    endfunction

    function automatic block_t set_byte(block_t b, logic [3:0] i, byte_t v);
        block_t r = b;
        r[{~i, 3'b000} +: 8] = v;
        return r;
    endfunction

    function automatic block_t inv_shift_rows(block_t s);
        block_t o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15 - (r + 4*c)) +: 8] = s[8*(15 - (r + 4*((c - r + 4) % 4))) +: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_mix_columns(block_t s);
        block_t o = '0;
        for (int c = 0; c < 4; c++) begin
            o[32*(3 - c) +: 32] = inv_mix_column(s[32*(3 - c) +: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational 256-entry lookup.
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y_o = TBL[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational 256-entry lookup (shared with the encrypt side).
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y_o = TBL[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/decrypt_re.sv
// Byte-serial AES-128 decryptor with on-the-fly inverse key schedule.
// Optional CBC chaining is enabled by defining AES_DEC_CBC_EN.
module decrypt_re
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] input_data,
    output logic       busy,
    output logic [7:0] output_data,
    output logic       output_ready
);
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  rnd_q, rnd_d;
    block_t      key_q, key_d;
    block_t      k10_q, k10_d;
    block_t      st_q, st_d;
    logic [23:0] sub_q, sub_d;
`ifdef AES_DEC_CBC_EN
    block_t      chain_q, chain_d;
    block_t      nchain_q, nchain_d;
`endif

    word_t  w3_src, rot, sub_full, exp_w0, exp_w1, exp_w2, exp_w3;
    byte_t  fsb_in, fsb_out, isb_in, isb_out, out_byte;
    block_t ark;

    // In ROUND cycle 0 the new w3 is not registered yet, so feed it straight in
    assign w3_src = (state_q == ROUND && cnt_q == 5'd0) ? (key_q[31:0] ^ key_q[63:32])
                                                        : key_q[31:0];
    assign rot    = {w3_src[23:0], w3_src[31:24]};
    assign fsb_in = rot[{~cnt_q[1:0], 3'b000} +: 8];
    assign isb_in = get_byte(st_q, cnt_q[3:0]);

    aes_sbox u_sbox (
        .a_i(fsb_in),
        .y_o(fsb_out)
    );

    aes_inv_sbox u_inv_sbox (
        .a_i(isb_in),
        .y_o(isb_out)
    );

    // Same w0 update serves both forward (EXPAND) and inverse (ROUND) key steps
    assign sub_full = {sub_q, fsb_out};
    assign exp_w0   = key_q[127:96] ^ sub_full ^ {rcon(rnd_q + 4'd1), 24'h000000};
    assign exp_w1   = key_q[95:64] ^ exp_w0;
    assign exp_w2   = key_q[63:32] ^ exp_w1;
    assign exp_w3   = key_q[31:0]  ^ exp_w2;
    assign ark      = inv_shift_rows(st_q) ^ key_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        k10_d   = k10_q;
        st_d    = st_q;
        sub_d   = sub_q;
`ifdef AES_DEC_CBC_EN
        chain_d  = chain_q;
        nchain_d = nchain_q;
`endif
        if (en) begin
            state_d = LOAD_KEY;
            cnt_d   = '0;
            rnd_d   = '0;
            k10_d   = '0;
        end else begin
            case (state_q)
                LOAD_KEY: begin
                    if (in_valid) begin
                        key_d = set_byte(key_q, cnt_q[3:0], input_data);
                        if (cnt_q == 5'd15) begin
                            state_d = EXPAND;
                            cnt_d   = '0;
                            rnd_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                EXPAND: begin
                    if (cnt_q[1:0] != 2'd3) begin
                        sub_d[{2'd2 - cnt_q[1:0], 3'b000} +: 8] = fsb_out;
                        cnt_d = cnt_q + 5'd1;
                    end else begin
                        key_d = {exp_w0, exp_w1, exp_w2, exp_w3};
                        cnt_d = '0;
                        if (rnd_q == 4'(NR - 1)) begin
                            k10_d = {exp_w0, exp_w1, exp_w2, exp_w3};
`ifdef AES_DEC_CBC_EN
                            state_d = LOAD_IV;
`else
                            state_d = READY;
`endif
                        end else begin
                            rnd_d = rnd_q + 4'd1;
                        end
                    end
                end
`ifdef AES_DEC_CBC_EN
                LOAD_IV: begin
                    if (in_valid) begin
                        chain_d = set_byte(chain_q, cnt_q[3:0], input_data);
                        if (cnt_q == 5'd15) begin
                            state_d = READY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
`endif
                READY, LOAD_CT: begin
                    if (in_valid) begin
                        st_d = set_byte(st_q, cnt_q[3:0], input_data ^ get_byte(k10_q, cnt_q[3:0]));
`ifdef AES_DEC_CBC_EN
                        nchain_d = set_byte(nchain_q, cnt_q[3:0], input_data);
`endif
                        if (cnt_q == 5'd15) begin
                            state_d = ROUND;
                            cnt_d   = '0;
                            rnd_d   = 4'(NR - 1);
                            key_d   = k10_q;
                        end else begin
                            state_d = LOAD_CT;
                            cnt_d   = cnt_q + 5'd1;
                        end
                    end
                end
                ROUND: begin
                    if (!cnt_q[4]) st_d = set_byte(st_q, cnt_q[3:0], isb_out);
                    if (cnt_q == 5'd0)
                        key_d[95:0] = {key_q[95:64] ^ key_q[127:96],
                                       key_q[63:32] ^ key_q[95:64],
                                       key_q[31:0]  ^ key_q[63:32]};
                    if (cnt_q < 5'd3) sub_d[{2'd2 - cnt_q[1:0], 3'b000} +: 8] = fsb_out;
                    if (cnt_q == 5'd3) key_d[127:96] = exp_w0;
                    if (cnt_q == 5'd16) begin
                        st_d  = (rnd_q == 4'd0) ? ark : inv_mix_columns(ark);
                        cnt_d = '0;
                        if (rnd_q == 4'd0) state_d = OUTPUT;
                        else               rnd_d   = rnd_q - 4'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                OUTPUT: begin
                    if (cnt_q == 5'd15) begin
                        state_d = READY;
                        cnt_d   = '0;
`ifdef AES_DEC_CBC_EN
                        chain_d = nchain_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rnd_q   <= '0;
            key_q   <= '0;
            k10_q   <= '0;
            st_q    <= '0;
            sub_q   <= '0;
`ifdef AES_DEC_CBC_EN
            chain_q  <= '0;
            nchain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            k10_q   <= k10_d;
            st_q    <= st_d;
            sub_q   <= sub_d;
`ifdef AES_DEC_CBC_EN
            chain_q  <= chain_d;
            nchain_q <= nchain_d;
`endif
        end
    end

`ifdef AES_DEC_CBC_EN
    assign out_byte = get_byte(st_q, cnt_q[3:0]) ^ get_byte(chain_q, cnt_q[3:0]);
`else
    assign out_byte = get_byte(st_q, cnt_q[3:0]);
`endif

    assign busy         = (state_q == LOAD_KEY) || (state_q == EXPAND) ||
                          (state_q == ROUND)    || (state_q == OUTPUT);
    assign output_ready = (state_q == OUTPUT);
    assign output_data  = (state_q == OUTPUT) ? out_byte : 8'h00;

endmodule

// File: doc/decrypt_re.md
Name: decrypt_re

Overview:
Byte-serial, low-area AES-128 decryptor. It is the receive-side counterpart of the byte-serial encryptor and uses the same 8-bit stream interface.
- Operation: load a 16-byte cipher key, expand it forward once to the last round key K10, then decrypt 16-byte ciphertext blocks. Each block runs 10 inverse rounds with an on-the-fly inverse key schedule, and the 16 plaintext bytes are streamed out.
- Datapath: one inverse S-box for state bytes and one forward S-box for the key schedule.

Parameters:
- None. AES-128 only; NR = 10 is a constant in aes_pkg.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  one-cycle pulse: start key load (aborts any operation in progress)
- in_valid  input  1  qualifies input_data (key, IV and ciphertext bytes)
- input_data  input  8  byte stream, FIPS-197 byte 0 first
- busy  output  1  high in LOAD_KEY, EXPAND, ROUND, OUTPUT
- output_data  output  8  plaintext byte
- output_ready  output  1  high for exactly 16 consecutive cycles per block

Behaviour:
- Reset values:
  - state = IDLE; busy = 0; output_ready = 0; output_data = 8'h00.
  - State, key, K10 and byte/round counters are all cleared.
- States:
  - IDLE -> LOAD_KEY on en.
  - LOAD_KEY: accepts 16 in_valid bytes into the key register; after the 16th -> EXPAND.
  - EXPAND: 10 steps × 4 cycles = 40 cycles. In cycles 0-3 of each step, the forward S-box processes RotWord(w3) byte by byte. On cycle 3, w0..w3 are updated with RCON[step]. Afterwards, K10 is copied to the k10 register -> READY.
  - READY (busy = 0): the first in_valid byte -> LOAD_CT.
  - LOAD_CT: ciphertext byte i is XORed with k10 byte i on arrival (initial AddRoundKey). After the 16th byte -> ROUND with work key = K10 and r = 9.
  - ROUND: 17 cycles per round, rounds r = 9 down to 0.
    - Cycles 0-15: state byte c <= InvSbox(byte c).
    - Cycles 0-3 (in parallel): inverse key step. w3..w1 are recomputed by XOR chain from the previous round key; the forward S-box processes RotWord(new w3); on cycle 3, w0 ^= SubWord ^ RCON[r+1].
    - Cycle 16: state <= InvMixColumns(InvShiftRows(state) ^ Kr). InvMixColumns is skipped when r = 0.
    - After r = 0 -> OUTPUT.
  - OUTPUT: 16 cycles, output_data = state byte 0..15, output_ready = 1 -> READY.
- Latency:
  - Key: with the last key byte at cycle k, EXPAND occupies k+1..k+40; busy falls at k+41.
  - Block: with the last ciphertext byte at cycle n, ROUND occupies n+1..n+170 and OUTPUT n+171..n+186; READY at n+187.
- in_valid outside LOAD_KEY, READY and LOAD_CT is ignored; bytes are dropped, not queued.
- Gaps in in_valid during LOAD_KEY or LOAD_CT pause the byte counter; there is no timeout.
- en in any state (including mid-ROUND or mid-OUTPUT): next cycle LOAD_KEY, output_ready = 0, counters cleared; the k10 register is invalidated.
- en and in_valid in the same cycle: en wins and the byte is discarded.
- rst has priority over en.
- k10 is preserved across blocks; a new key is required only after en or rst.

Optional Feature:
- Macro: AES_DEC_CBC_EN.
- Defined:
  - After EXPAND, the block enters LOAD_IV and accepts 16 in_valid bytes into the chain register (busy = 0 while waiting), then READY.
  - Each raw ciphertext is captured into next_chain during LOAD_CT.
  - OUTPUT byte i = state[i] ^ chain[i]; chain <= next_chain at the end of OUTPUT.
- Undefined: ECB mode only; no LOAD_IV state; the chain registers are absent.

Decomposition:
- Shared package aes_pkg:
  - NR = 10
  - RCON[1..10]
  - state enum (IDLE, LOAD_KEY, EXPAND, LOAD_IV, READY, LOAD_CT, ROUND, OUTPUT)
  - byte/word/block typedefs
  - gf_mul2/xtime and InvMixColumn-column functions
- Sub-module: aes_inv_sbox (combinational 256-entry LUT). The forward S-box is the existing encrypt-side aes_sbox instance.

Test Plan:
- Reset then en, key 000102…0f, then ct 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff; output_ready high exactly 16 cycles starting n+171; the internal k10 equals 13111d7fe3944a17f307a78b4d2b30c5.
- Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Repeat the same ct back-to-back without reloading the key → identical output.
- in_valid toggled 1/0 during key and ciphertext load (32 cycles per 16 bytes) → the same results as the first two scenarios; busy low during READY.
- en pulsed at ROUND cycle 80 → output_ready never asserts for that block; reload key and ct from the first scenario → correct plaintext.
- in_valid bytes injected during ROUND and OUTPUT → ignored; output is unchanged and the next block decrypts correctly.
- With AES_DEC_CBC_EN: key 2b7e…4f3c, IV 000102…0f, ct 7649abac8119b246cee98e9b12e9197d → 6bc1bee22e409f96e93d7e117393172a; a second block 5086cb9b507219ee95db113a917678b2 → ae2d8a571e03ac9c9eb76fac45af8e51.
